// File: rtl/despread_pkg.sv
// Shared constants for the 802.11b Barker despreader: code length, chip code, correlator width.
package despread_pkg;

   localparam int CHIPS  = 11;
   localparam int CORR_W = 20;

   // Bit k set means chip c[k] = +1, clear means -1; c[0] is the first chip received.
   localparam logic [CHIPS-1:0] BARKER = 11'b000_1110_1101;

   typedef logic [3:0] chip_idx_t;

   function automatic logic [CORR_W-1:0] abs_corr(input logic signed [CORR_W-1:0] v);
      return v[CORR_W-1] ? CORR_W'(-v) : CORR_W'(v);
   endfunction

endpackage

// File: rtl/barker_corr.sv
// One rail of the despreader: chip delay line plus signed Barker correlator.
// The correlation output already includes the sample presented on din this cycle.
module barker_corr
   import despread_pkg::*;
#(
   parameter int IW = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     strobe,
   input  logic signed [IW-1:0]     din,
   output logic signed [CORR_W-1:0] corr
);

   // The oldest of the 11 chips is the incoming sample's partner once shifted,
   // so only the ten previous chips need storage.
   logic signed [IW-1:0] d [CHIPS-1];

   // NOTE: the delay line is only 10 words, so it is reset explicitly; wider sample
   // memories would normally be left unreset and qualified by a valid flag instead.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < CHIPS - 1; k++) d[k] <= '0;
      end else if (strobe) begin
         d[0] <= din;
         for (int k = 1; k < CHIPS - 1; k++) d[k] <= d[k-1];
      end
   end

   logic signed [CORR_W-1:0] term;
   logic signed [CORR_W-1:0] acc;

   // NOTE: every variable in this block is assigned first, so no latch can be inferred.
   always_comb begin
      acc  = '0;
      term = {{(CORR_W-IW){din[IW-1]}}, din};
      acc  = BARKER[CHIPS-1] ? acc + term : acc - term;
      for (int k = 0; k < CHIPS - 1; k++) begin
         term = {{(CORR_W-IW){d[CHIPS-2-k][IW-1]}}, d[CHIPS-2-k]};
         acc  = BARKER[k] ? acc + term : acc - term;
      end
      corr = acc;
   end

endmodule

// File: rtl/despreading.sv
// 802.11b DSSS Barker despreader, RX channel 0: one despread I/Q pair per 11 chips.
// Define DESPREAD_PEAK_TRACK_EN to enable the emit-phase peak tracker.
module despreading
   import despread_pkg::*;
#(
   parameter int IW         = 16,
   parameter int OW         = 16,
   parameter int SHIFT      = 4,
   parameter int TRACK_SYMS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic signed [IW-1:0] dataini,
   input  logic signed [IW-1:0] datainq,
   input  logic                 strobe_in,
   output logic signed [OW-1:0] dataouti,
   output logic signed [OW-1:0] dataoutq,
   output logic                 strobe_out
);

   logic signed [CORR_W-1:0] corr_i;
   logic signed [CORR_W-1:0] corr_q;
   chip_idx_t                chip_cnt;
   chip_idx_t                emit_phase;

   barker_corr #(.IW(IW)) u_corr_i (
      .clk    (clk),
      .reset  (reset),
      .strobe (strobe_in),
      .din    (dataini),
      .corr   (corr_i)
   );

   barker_corr #(.IW(IW)) u_corr_q (
      .clk    (clk),
      .reset  (reset),
      .strobe (strobe_in),
      .din    (datainq),
      .corr   (corr_q)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         chip_cnt   <= '0;
         dataouti   <= '0;
         dataoutq   <= '0;
         strobe_out <= 1'b0;
      end else begin
         strobe_out <= 1'b0;
         if (strobe_in) begin
            chip_cnt <= (chip_cnt == chip_idx_t'(CHIPS - 1)) ? '0 : chip_cnt + 1'b1;
            if (chip_cnt == emit_phase) begin
               dataouti   <= OW'(corr_i >>> SHIFT);
               dataoutq   <= OW'(corr_q >>> SHIFT);
               strobe_out <= 1'b1;
            end
         end
      end
   end

`ifdef DESPREAD_PEAK_TRACK_EN
   localparam int WIN   = CHIPS * TRACK_SYMS;
   localparam int WIN_W = $clog2(WIN);

   logic [23:0]      acc     [CHIPS];
   logic [23:0]      acc_upd [CHIPS];
   logic [23:0]      mag;
   logic [23:0]      best_val;
   chip_idx_t        best_idx;
   logic [WIN_W-1:0] win_cnt;

   // Energy of the current chip lands in the accumulator for its phase; the argmax
   // below sees this final contribution when the window closes on this strobe.
   always_comb begin
      mag      = 24'(abs_corr(corr_i)) + 24'(abs_corr(corr_q));
      best_val = '0;
      best_idx = '0;
      for (int k = 0; k < CHIPS; k++) begin
         acc_upd[k] = (chip_idx_t'(k) == chip_cnt) ? acc[k] + mag : acc[k];
         if (k == 0 || acc_upd[k] > best_val) begin
            best_val = acc_upd[k];
            best_idx = chip_idx_t'(k);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < CHIPS; k++) acc[k] <= '0;
         win_cnt    <= '0;
         emit_phase <= chip_idx_t'(CHIPS - 1);
      end else if (strobe_in) begin
         if (win_cnt == WIN_W'(WIN - 1)) begin
            for (int k = 0; k < CHIPS; k++) acc[k] <= '0;
            win_cnt    <= '0;
            emit_phase <= best_idx;
         end else begin
            for (int k = 0; k < CHIPS; k++) acc[k] <= acc_upd[k];
            win_cnt <= win_cnt + 1'b1;
         end
      end
   end
`else
   assign emit_phase = chip_idx_t'(CHIPS - 1);
`endif

endmodule

// File: tb/tb_despreading.sv
// Scoreboard bench for the Barker despreader: stimulus pushes expected symbols,
// a negedge monitor pops and compares on every strobe_out.
module tb_despreading;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic signed [15:0] dataini = '0;
   logic signed [15:0] datainq = '0;
   logic               strobe_in = 1'b0;
   logic signed [15:0] dataouti;
   logic signed [15:0] dataoutq;
   logic               strobe_out;

   typedef struct {
      int i;
      int q;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   code [11] = '{1, -1, 1, 1, -1, 1, 1, 1, -1, -1, -1};

   despreading dut (
      .clk        (clk),
      .reset      (reset),
      .dataini    (dataini),
      .datainq    (datainq),
      .strobe_in  (strobe_in),
      .dataouti   (dataouti),
      .dataoutq   (dataoutq),
      .strobe_out (strobe_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && strobe_out) begin
         if (sb.size() == 0) begin
            check("spurious_strobe_out", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("symbol_i", int'(dataouti), e.i);
            check("symbol_q", int'(dataoutq), e.q);
         end
      end
   end

   task automatic push_exp(input int ei, input int eq);
      exp_t e;
      e.i = ei;
      e.q = eq;
      sb.push_back(e);
   endtask

   task automatic send(input int si, input int sq, input int gap);
      dataini   = 16'(si);
      datainq   = 16'(sq);
      strobe_in = 1'b1;
      @(posedge clk); #1;
      strobe_in = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   // Sends one 11-chip symbol; dc selects a constant rail instead of Barker-modulated.
   task automatic send_symbol(input int si, input int sq, input bit dc, input int gap,
                              input int ei, input int eq);
      for (int k = 0; k < 11; k++) begin
         if (k == 10) push_exp(ei, eq);
         send(dc ? si : si * code[k], dc ? sq : sq * code[k], gap);
      end
   endtask

   task automatic drain(input string name);
      int budget = 20;
      while (sb.size() != 0 && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      repeat (3) begin
         @(posedge clk); #1;
      end
      check(name, sb.size(), 0);
      sb.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      @(posedge clk); #1;
      do_reset();
      check("reset_i", int'(dataouti), 0);
      check("reset_q", int'(dataoutq), 0);
      check("reset_strobe", int'(strobe_out), 0);

      send_symbol(1600, 0, 1'b0, 0, 1100, 0);
      drain("t1_drain");
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("t1_hold_i", int'(dataouti), 1100);

      send_symbol(-1600, 1600, 1'b0, 0, -1100, 1100);
      drain("t2_drain");

      send_symbol(1600, 1600, 1'b1, 0, 100, 100);
      drain("t3_drain");

      send_symbol(1600, 0, 1'b0, 3, 1100, 0);
      drain("t4_drain");
      send_symbol(-1600, 0, 1'b0, 3, -1100, 0);
      drain("t4b_drain");

      for (int k = 0; k < 5; k++) send(1600 * code[k], 0, 0);
      do_reset();
      check("t5_reset_i", int'(dataouti), 0);
      check("t5_reset_q", int'(dataoutq), 0);
      check("t5_reset_strobe", int'(strobe_out), 0);
      send_symbol(1600, 0, 1'b0, 0, 1100, 0);
      drain("t5_drain");

`ifdef DESPREAD_PEAK_TRACK_EN
      begin
         int hist [11];
         int cnt   = 0;
         int phase = 10;
         int n     = 0;
         do_reset();
         for (int k = 0; k < 11; k++) hist[k] = 0;
         for (int s = 0; s < 3 + 11 * 19; s++) begin
            int v;
            int corr;
            v = (s < 3) ? 0 : 1600 * code[(s - 3) % 11];
            for (int k = 10; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = v;
            n++;
            if (cnt == phase) begin
               if (n > 176) begin
                  push_exp(1100, 0);
               end else begin
                  corr = 0;
                  for (int k = 0; k < 11; k++) corr += code[k] * hist[10-k];
                  push_exp(corr >>> 4, 0);
               end
            end
            cnt = (cnt == 10) ? 0 : cnt + 1;
            if (n == 176) phase = 2;
            send(v, 0, 0);
         end
         drain("t6_drain");
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
